// File: rtl/hera_pkg.sv
// Shared HERA core definitions: address widths, default vectors and the
// next-PC sequencer state encoding.
package hera_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned ROM_AW = 10;

  localparam logic [ROM_AW-1:0] DEF_RESET_VEC   = 10'h000;
  localparam logic [ROM_AW-1:0] DEF_IRQ_VEC     = 10'h002;
  localparam logic [PC_W-1:0]   DEF_STACK_BASE  = 16'hFF00;
  localparam int unsigned       DEF_STACK_DEPTH = 16;

  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Next-PC controller for the HERA fetch stage. Selects the ROM fetch address
// from hold / return / call / branch / interrupt / sequential sources, keeps
// the architectural pc and a return-address stack held in data RAM.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   stall             hold current pc
//   branch_taken      jump to target
//   call_req          push pc+1, jump to target
//   ret_req           pop return address (two cycles, one bubble)
//   target[15:0]      branch/call destination, [9:0] used
//   irq               level interrupt request
//   q[15:0]           RAM read data, one cycle after a read strobe
//   npc[9:0]          ROM fetch address (combinational)
//   pc[15:0]          registered current pc
//   mem_en, mem_we    RAM strobe / write enable (combinational)
//   mem_addr[15:0]    RAM address (combinational)
//   mem_wdata[15:0]   pushed return address (combinational)
//   bubble            current fetch is a dead slot (combinational)
//   in_irq            interrupt handler active (registered)
//   fault             sticky stack overflow/underflow (registered)
module pc_sequencer
  import hera_pkg::*;
#(
  parameter logic [ROM_AW-1:0] RESET_VEC   = DEF_RESET_VEC,
  parameter logic [ROM_AW-1:0] IRQ_VEC     = DEF_IRQ_VEC,
  parameter logic [PC_W-1:0]   STACK_BASE  = DEF_STACK_BASE,
  parameter int unsigned       STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [PC_W-1:0]   target,
  input  logic              irq,
  input  logic [PC_W-1:0]   q,
  output logic [ROM_AW-1:0] npc,
  output logic [PC_W-1:0]   pc,
  output logic              mem_en,
  output logic              mem_we,
  output logic [PC_W-1:0]   mem_addr,
  output logic [PC_W-1:0]   mem_wdata,
  output logic              bubble,
  output logic              in_irq,
  output logic              fault
);

  // sp counts 0..STACK_DEPTH inclusive, so it needs one extra bit
  localparam int unsigned      SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

  seq_state_e        state, state_d;
  logic [SP_W-1:0]   sp, sp_d;
  logic              in_irq_d;
  logic              fault_d;
  logic [ROM_AW-1:0] pc_inc;
  logic [PC_W-1:0]   push_addr;
  logic [PC_W-1:0]   pop_addr;
  logic              stack_full;
  logic              stack_empty;
  logic              unused_hi_bits;

  assign pc_inc      = pc[ROM_AW-1:0] + ROM_AW'(1);
  assign push_addr   = STACK_BASE + PC_W'(sp);
  assign pop_addr    = STACK_BASE + PC_W'(sp) - PC_W'(1);
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  // Only the ROM-address bits of target and q are meaningful
  assign unused_hi_bits = ^{target[PC_W-1:ROM_AW], q[PC_W-1:ROM_AW]};

  // State, pc, stack pointer and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      pc     <= PC_W'(RESET_VEC);
      sp     <= '0;
      in_irq <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= PC_W'(npc);
      sp     <= sp_d;
      in_irq <= in_irq_d;
      fault  <= fault_d;
    end
  end

  // Next-PC source selection, stack sequencing and RAM strobes
  always_comb begin
    state_d   = state;
    sp_d      = sp;
    in_irq_d  = in_irq;
    fault_d   = fault;
    npc       = pc_inc;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bubble    = 1'b0;

    case (state)
      RET_WAIT: begin
        // Popped address arrives now; every request input is ignored
        npc      = q[ROM_AW-1:0];
        in_irq_d = 1'b0;
        state_d  = RUN;
      end
      default: begin
        if (stall) begin
          npc = pc[ROM_AW-1:0];
        end else if (ret_req) begin
          if (stack_empty) begin
            fault_d = 1'b1;
          end else begin
            mem_en   = 1'b1;
            mem_addr = pop_addr;
            sp_d     = sp - SP_W'(1);
            npc      = pc[ROM_AW-1:0];
            bubble   = 1'b1;
            state_d  = RET_WAIT;
          end
        end else if (call_req) begin
          if (stack_full) begin
            fault_d = 1'b1;
          end else begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = push_addr;
            mem_wdata = PC_W'(pc_inc);
            sp_d      = sp + SP_W'(1);
            npc       = target[ROM_AW-1:0];
          end
        end else if (branch_taken) begin
          npc = target[ROM_AW-1:0];
        end else if (irq && !in_irq) begin
          // Interrupt entry behaves as a call to IRQ_VEC; on overflow it
          // degrades to a faulting sequential fetch like a call does
          if (stack_full) begin
            fault_d = 1'b1;
          end else begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = push_addr;
            mem_wdata = PC_W'(pc_inc);
            sp_d      = sp + SP_W'(1);
            npc       = IRQ_VEC;
            in_irq_d  = 1'b1;
          end
        end
      end
    endcase

    // Combinational outputs must read as reset values while rst is low
    if (!rst) begin
      npc       = RESET_VEC;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      bubble    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the stimulus thread queues the expected
// outputs for each cycle it drives, a monitor pops and compares at negedge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall, branch_taken, call_req, ret_req, irq;
  logic [15:0] target;
  logic [15:0] q;
  logic [9:0]  npc;
  logic [15:0] pc;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        bubble, in_irq, fault;

  typedef struct {
    logic [9:0]  npc;
    logic [15:0] pc;
    logic        bub;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        irq;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] x_pc;
  logic        x_irq, x_flt;
  logic [15:0] ram [16];

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R_ST   = 5'b10000;
  localparam logic [4:0] R_RET  = 5'b01000;
  localparam logic [4:0] R_CALL = 5'b00100;
  localparam logic [4:0] R_BR   = 5'b00010;
  localparam logic [4:0] R_IRQ  = 5'b00001;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .call_req     (call_req),
    .ret_req      (ret_req),
    .target       (target),
    .irq          (irq),
    .q            (q),
    .npc          (npc),
    .pc           (pc),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .bubble       (bubble),
    .in_irq       (in_irq),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM model covering the 16 stack entries
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[3:0]] <= mem_wdata;
    else if (mem_en)      q <= ram[mem_addr[3:0]];
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("npc",       16'(npc),       16'(e.npc));
        chk("pc",        pc,             e.pc);
        chk("bubble",    16'(bubble),    16'(e.bub));
        chk("mem_en",    16'(mem_en),    16'(e.en));
        chk("mem_we",    16'(mem_we),    16'(e.we));
        chk("mem_addr",  mem_addr,       e.addr);
        chk("mem_wdata", mem_wdata,      e.wd);
        chk("in_irq",    16'(in_irq),    16'(e.irq));
        chk("fault",     16'(fault),     16'(e.flt));
      end
    end
  end

  // One stimulus cycle: drive requests, queue expected outputs, advance
  task automatic cyc(input logic [4:0] req, input logic [15:0] tg,
                     input logic [9:0] e_npc, input logic e_bub,
                     input logic e_en, input logic e_we,
                     input logic [15:0] e_addr, input logic [15:0] e_wd);
    exp_t e;
    stall        = req[4];
    ret_req      = req[3];
    call_req     = req[2];
    branch_taken = req[1];
    irq          = req[0];
    target       = tg;
    e.npc  = e_npc;
    e.pc   = x_pc;
    e.bub  = e_bub;
    e.en   = e_en;
    e.we   = e_we;
    e.addr = e_addr;
    e.wd   = e_wd;
    e.irq  = x_irq;
    e.flt  = x_flt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x_pc = {6'b0, e_npc};
  endtask

  task automatic free(input logic [9:0] e_npc);
    cyc(R_NONE, 16'h0000, e_npc, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic reset_check();
    rst   = 1'b0;
    x_pc  = 16'h0000;
    x_irq = 1'b0;
    x_flt = 1'b0;
    free(10'h000);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; call_req = 1'b0; ret_req = 1'b0; irq = 1'b0;
    target = 16'h0000;
    x_pc = 16'h0000; x_irq = 1'b0; x_flt = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then sequential fetch
    reset_check();
    free(10'h001);
    free(10'h002);
    free(10'h003);

    // Call from 010 to 100, return from 105
    cyc(R_BR,   16'h0010, 10'h010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_CALL, 16'h0100, 10'h100, 1'b0, 1'b1, 1'b1, 16'hFF00, 16'h0011);
    for (int i = 1; i <= 5; i++) free(10'h100 + 10'(i));
    cyc(R_RET,  16'h0000, 10'h105, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000);
    free(10'h011);

    // Interrupt entry at 020, second irq ignored, return clears in_irq
    cyc(R_BR,   16'h0020, 10'h020, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_IRQ,  16'h0000, 10'h002, 1'b0, 1'b1, 1'b1, 16'hFF00, 16'h0021);
    x_irq = 1'b1;
    cyc(R_IRQ,  16'h0000, 10'h003, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_RET,  16'h0000, 10'h003, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000);
    cyc(R_ST | R_CALL, 16'h0300, 10'h021, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    x_irq = 1'b0;
    free(10'h022);

    // Stall at 040 overrides call and irq
    cyc(R_BR,   16'h0040, 10'h040, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_ST,   16'h0000, 10'h040, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_ST | R_CALL, 16'h0300, 10'h040, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(R_ST | R_IRQ,  16'h0000, 10'h040, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset during RET_WAIT aborts the pop
    cyc(R_CALL, 16'h0050, 10'h050, 1'b0, 1'b1, 1'b1, 16'hFF00, 16'h0041);
    cyc(R_RET,  16'h0000, 10'h050, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000);
    reset_check();
    free(10'h001);

    // sp is 0 after reset: return underflows, sequential fetch, no RAM access
    cyc(R_RET,  16'h0000, 10'h002, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    x_flt = 1'b1;
    free(10'h003);

    // Fill the stack, 17th call overflows
    reset_check();
    for (int i = 0; i < 16; i++)
      cyc(R_CALL, 16'h0200 + 16'(i), 10'h200 + 10'(i), 1'b0, 1'b1, 1'b1,
          16'hFF00 + 16'(i), (i == 0) ? 16'h0001 : 16'h0200 + 16'(i));
    cyc(R_CALL, 16'h0300, 10'h210, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    x_flt = 1'b1;
    cyc(R_RET,  16'h0000, 10'h210, 1'b1, 1'b1, 1'b0, 16'hFF0F, 16'h0000);
    free(10'h20F);
    free(10'h210);

    repeat (2) @(posedge clk);
    chk("scoreboard_drain", 16'(sb.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
